// File: rtl/match_pkg.sv
// Shared widths and loader state encoding for the match accelerator and its region loader.
package match_pkg;

  localparam int MATCH_ROWS  = 64;
  localparam int MATCH_ROW_W = 24;
  localparam int MATCH_BMR_W = MATCH_ROWS * MATCH_ROW_W;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_REQ,
    LD_WAIT,
    LD_START,
    LD_MATCH
  } match_ld_state_t;

endpackage

// File: rtl/match_addr_gen.sv
// Row counter plus running read address: base + row*stride built by repeated addition.
module match_addr_gen #(
  parameter int ROWS   = 64,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  row,
  output logic              last
);

  logic [CNT_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;

  always_comb begin
    row_d    = row_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    if (clear) begin
      row_d    = '0;
      addr_d   = base;
      stride_d = stride;
    end else if (step) begin
      // Address wraps modulo 2^ADDR_W by construction.
      row_d  = row_q + CNT_W'(1);
      addr_d = addr_q + stride_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q    <= '0;
      addr_q   <= '0;
      stride_q <= '0;
    end else begin
      row_q    <= row_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
    end
  end

  assign addr = addr_q;
  assign row  = row_q;
  assign last = (row_q == CNT_W'(ROWS - 1));

endmodule

// File: rtl/match_region_loader.sv
// Reads ROWS rows from score memory into the bmr bus, kicks the accelerator, holds bmr until finish.
module match_region_loader
  import match_pkg::*;
#(
  parameter int ROWS   = MATCH_ROWS,
  parameter int ROW_W  = MATCH_ROW_W,
  parameter int MEM_W  = 32,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_req,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     row_stride,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_rvalid,
  input  logic [MEM_W-1:0]      mem_rdata,
  output logic [ROWS*ROW_W-1:0] bmr,
  output logic                  match_start,
  input  logic                  match_finish,
  output logic                  busy,
  output logic                  region_done
);

  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  match_ld_state_t state_q, state_d;
  logic [ROWS-1:0][ROW_W-1:0] bmr_q, bmr_d;

  logic [CNT_W-1:0] row;
  logic             last;
  logic             accept;
  logic             capture;

  assign accept  = (state_q == LD_IDLE) && load_req;
  assign capture = (state_q == LD_WAIT) && mem_rvalid;

  match_addr_gen #(
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .step   (capture && !last),
    .base   (base_addr),
    .stride (row_stride),
    .addr   (mem_addr),
    .row    (row),
    .last   (last)
  );

  always_comb begin
    state_d = state_q;
    bmr_d   = bmr_q;
    case (state_q)
      LD_IDLE: begin
        if (load_req) begin
          state_d = LD_REQ;
          bmr_d   = '0;
        end
      end
      LD_REQ:  state_d = LD_WAIT;
      LD_WAIT: begin
        if (mem_rvalid) begin
          bmr_d[row] = mem_rdata[ROW_W-1:0];
          state_d    = last ? LD_START : LD_REQ;
        end
      end
      LD_START: state_d = LD_MATCH;
      LD_MATCH: begin
        if (match_finish) state_d = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LD_IDLE;
      bmr_q   <= '0;
    end else begin
      state_q <= state_d;
      bmr_q   <= bmr_d;
    end
  end

  // Upper memory bits beyond the row width carry no region data.
  generate
    if (MEM_W > ROW_W) begin : g_hi
      logic unused_rdata_hi;
      assign unused_rdata_hi = ^mem_rdata[MEM_W-1:ROW_W];
    end
  endgenerate

  assign bmr         = bmr_q;
  assign mem_rd      = (state_q == LD_REQ);
  assign match_start = (state_q == LD_START);
  assign busy        = (state_q != LD_IDLE);
  assign region_done = (state_q == LD_MATCH) && match_finish;

endmodule
